// File: rtl/sbox_layer_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sbox_layer_seq_pkg
//  Purpose  : Shared FSM encoding, issue count and S-box BRAM address layout.
//  Revision : 1.0
// ============================================================================
package sbox_layer_seq_pkg;

    localparam int SBOX_NBYTES = 16;
    localparam int SBOX_NPAIRS = SBOX_NBYTES / 2;

    // BRAM address = {tsel, data byte}; the BRAM wrappers share this layout.
    localparam int ADDR_W   = 10;
    localparam int TSEL_MSB = 9;
    localparam int TSEL_LSB = 8;
    localparam int TSEL_W   = TSEL_MSB - TSEL_LSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    function automatic logic [ADDR_W-1:0] sbox_addr(input logic [TSEL_W-1:0] tsel,
                                                    input logic [7:0]        b);
        logic [ADDR_W-1:0] a;
        a                    = '0;
        a[TSEL_MSB:TSEL_LSB] = tsel;
        a[TSEL_LSB-1:0]      = b;
        return a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_layer_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : sbox_layer_seq_if
//  Purpose  : Request/result handshake plus dual-port S-box BRAM bus.
//  Revision : 1.0
// ============================================================================
interface sbox_layer_seq_if #(
    parameter int NBYTES = sbox_layer_seq_pkg::SBOX_NBYTES
);
    import sbox_layer_seq_pkg::*;

    logic                  start;
    logic [TSEL_W-1:0]     tsel;
    logic [8*NBYTES-1:0]   state_in;
    logic                  ready;
    logic                  bram_en;
    logic [ADDR_W-1:0]     bram_addra;
    logic [ADDR_W-1:0]     bram_addrb;
    logic [7:0]            bram_doa;
    logic [7:0]            bram_dob;
    logic [8*NBYTES-1:0]   state_out;
    logic                  done;

    // Environment side: requester plus BRAM data return.
    modport master (
        output start, tsel, state_in, bram_doa, bram_dob,
        input  ready, bram_en, bram_addra, bram_addrb, state_out, done
    );

    // Sequencer side.
    modport slave (
        input  start, tsel, state_in, bram_doa, bram_dob,
        output ready, bram_en, bram_addra, bram_addrb, state_out, done
    );

endinterface
`default_nettype wire

// File: rtl/sbox_rd_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : sbox_rd_tracker
//  Purpose  : RD_LAT-deep valid/pair-index shift register for in-flight reads.
//  Revision : 1.0
// ============================================================================
module sbox_rd_tracker #(
    parameter int RD_LAT = 2,
    parameter int IDX_W  = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_valid,
    input  wire logic [IDX_W-1:0] i_idx,
    output logic                  o_valid,
    output logic [IDX_W-1:0]      o_idx
);

    logic [RD_LAT-1:0]            vld_q, vld_d;
    logic [RD_LAT-1:0][IDX_W-1:0] idx_q, idx_d;

    generate
        if (RD_LAT == 1) begin : g_single
            always_comb begin
                vld_d = i_valid;
                idx_d = i_idx;
            end
        end else begin : g_multi
            always_comb begin
                vld_d = {vld_q[RD_LAT-2:0], i_valid};
                idx_d = {idx_q[RD_LAT-2:0], i_idx};
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q <= vld_d;
            idx_q <= idx_d;
        end
    end

    assign o_valid = vld_q[RD_LAT-1];
    assign o_idx   = idx_q[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/sbox_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module   : sbox_layer_seq
//  Purpose  : Streams a masked state two bytes per cycle through a dual-port
//             S-box BRAM and reassembles the substituted bytes.
//  Revision : 1.0
// ============================================================================
module sbox_layer_seq
    import sbox_layer_seq_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int NBYTES = SBOX_NBYTES
) (
    input  wire logic       clk,
    input  wire logic       rst,
    sbox_layer_seq_if.slave bus
);

    localparam int NPAIRS = NBYTES / 2;
    localparam int IDX_W  = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
    localparam int DRN_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    seq_state_e                state_q, state_d;
    logic [IDX_W-1:0]          k_q, k_d;
    logic [DRN_W-1:0]          drn_q, drn_d;
    logic [TSEL_W-1:0]         tsel_q, tsel_d;
    logic [NBYTES-1:0][7:0]    state_in_q, state_in_d;
    logic [NBYTES-1:0][7:0]    state_out_q, state_out_d;

    logic                      issue;
    logic                      bram_en;
    logic                      trk_valid;
    logic [IDX_W-1:0]          trk_idx;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        drn_d      = drn_q;
        tsel_d     = tsel_q;
        state_in_d = state_in_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d    = ST_ISSUE;
                    k_d        = '0;
                    tsel_d     = bus.tsel;
                    state_in_d = bus.state_in;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // k stays on the last pair so DRAIN keeps presenting its address.
                if (k_q == IDX_W'(NPAIRS - 1)) begin
                    state_d = ST_DRAIN;
                    drn_d   = '0;
                end else begin
                    k_d     = k_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drn_q == DRN_W'(RD_LAT - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    drn_d   = drn_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        state_out_d = state_out_q;
        if (trk_valid) begin
            state_out_d[{trk_idx, 1'b0}] = bus.bram_doa;
            state_out_d[{trk_idx, 1'b1}] = bus.bram_dob;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            drn_q       <= '0;
            tsel_q      <= '0;
            state_in_q  <= '0;
            state_out_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            drn_q       <= drn_d;
            tsel_q      <= tsel_d;
            state_in_q  <= state_in_d;
            state_out_q <= state_out_d;
        end
    end

    assign issue   = (state_q == ST_ISSUE);
    assign bram_en = issue || (state_q == ST_DRAIN);

    sbox_rd_tracker #(
        .RD_LAT (RD_LAT),
        .IDX_W  (IDX_W)
    ) u_trk (
        .clk     (clk),
        .rst     (rst),
        .i_valid (issue),
        .i_idx   (k_q),
        .o_valid (trk_valid),
        .o_idx   (trk_idx)
    );

    assign bus.bram_en    = bram_en;
    assign bus.bram_addra = bram_en ? sbox_addr(tsel_q, state_in_q[{k_q, 1'b0}]) : '0;
    assign bus.bram_addrb = bram_en ? sbox_addr(tsel_q, state_in_q[{k_q, 1'b1}]) : '0;
    assign bus.ready      = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.state_out  = state_out_q;

endmodule
`default_nettype wire

// File: tb/tb_sbox_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sbox_layer_seq
//  Purpose  : Scoreboard bench for sbox_layer_seq at RD_LAT=2 and RD_LAT=1.
//  Revision : 1.0
// ============================================================================
module tb_sbox_layer_seq;
    import sbox_layer_seq_pkg::*;

    typedef struct {
        int         cyc;
        logic [9:0] a;
        logic [9:0] b;
    } sched_t;

    typedef struct {
        int           cyc;
        logic [127:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   last_done [2];

    sched_t sq0[$], sq1[$];
    exp_t   eq0[$], eq1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sbox_layer_seq_if #(.NBYTES(16)) bus0 ();
    sbox_layer_seq_if #(.NBYTES(16)) bus1 ();

    sbox_layer_seq #(.RD_LAT(2), .NBYTES(16)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sbox_layer_seq #(.RD_LAT(1), .NBYTES(16)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // BRAM models: read data = addr[7:0] ^ table select.
    function automatic logic [7:0] bram_rd(input logic [9:0] a);
        return a[7:0] ^ {6'b0, a[9:8]};
    endfunction

    logic [7:0] b0a1 = 8'h0, b0a2 = 8'h0, b0b1 = 8'h0, b0b2 = 8'h0;
    logic [7:0] b1a = 8'h0, b1b = 8'h0;

    always @(posedge clk) begin
        if (bus0.bram_en) begin
            b0a1 <= bram_rd(bus0.bram_addra);
            b0b1 <= bram_rd(bus0.bram_addrb);
            b0a2 <= b0a1;
            b0b2 <= b0b1;
        end
        if (bus1.bram_en) begin
            b1a <= bram_rd(bus1.bram_addra);
            b1b <= bram_rd(bus1.bram_addrb);
        end
    end

    assign bus0.bram_doa = b0a2;
    assign bus0.bram_dob = b0b2;
    assign bus1.bram_doa = b1a;
    assign bus1.bram_dob = b1b;

    function automatic logic [127:0] ref_sub(input logic [127:0] st, input logic [1:0] ts);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = st[8*i +: 8] ^ {6'b0, ts};
        return r;
    endfunction

    task automatic check(input string nm, input int d, input logic [127:0] act,
                         input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, d, cyc, act, req);
        end
    endtask

    // Drive start for DUT d in the current cycle and record what must follow.
    task automatic launch(input int d, input logic [1:0] ts, input logic [127:0] st);
        int           lat;
        logic [127:0] sh;
        sched_t       s;
        exp_t         e;
        lat = (d == 0) ? 2 : 1;
        if (d == 0) begin
            bus0.start = 1'b1; bus0.tsel = ts; bus0.state_in = st;
        end else begin
            bus1.start = 1'b1; bus1.tsel = ts; bus1.state_in = st;
        end
        s.a = '0; s.b = '0;
        for (int k = 0; k < SBOX_NPAIRS; k++) begin
            sh    = st >> (16 * k);
            s.cyc = cyc + 1 + k;
            s.a   = {ts, sh[7:0]};
            s.b   = {ts, sh[15:8]};
            if (d == 0) sq0.push_back(s); else sq1.push_back(s);
        end
        for (int j = 0; j < lat; j++) begin
            s.cyc = cyc + 1 + SBOX_NPAIRS + j;
            if (d == 0) sq0.push_back(s); else sq1.push_back(s);
        end
        e.cyc = cyc + SBOX_NPAIRS + lat + 1;
        e.v   = ref_sub(st, ts);
        if (d == 0) eq0.push_back(e); else eq1.push_back(e);
        last_done[d] = e.cyc;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drop(input int d);
        @(posedge clk); #1;
        if (d == 0) bus0.start = 1'b0; else bus1.start = 1'b0;
    endtask

    task automatic mon(input int d, input logic en, input logic rdy, input logic dn,
                       input logic [9:0] aa, input logic [9:0] ab, input logic [127:0] so);
        sched_t s;
        exp_t   e;
        bit     hs, he;
        hs = 1'b0; he = 1'b0;
        s.a = '0; s.b = '0; e.v = '0;
        if (d == 0) begin
            if (sq0.size() > 0 && sq0[0].cyc == cyc) begin s = sq0.pop_front(); hs = 1'b1; end
            if (eq0.size() > 0 && eq0[0].cyc == cyc) begin e = eq0.pop_front(); he = 1'b1; end
        end else begin
            if (sq1.size() > 0 && sq1[0].cyc == cyc) begin s = sq1.pop_front(); hs = 1'b1; end
            if (eq1.size() > 0 && eq1[0].cyc == cyc) begin e = eq1.pop_front(); he = 1'b1; end
        end
        check("bram_en", d, en, hs);
        check("addra", d, aa, hs ? s.a : 10'h0);
        check("addrb", d, ab, hs ? s.b : 10'h0);
        check("ready", d, rdy, !hs);
        check("done", d, dn, he);
        if (he) check("state_out", d, so, e.v);
    endtask

    always @(negedge clk) mon(0, bus0.bram_en, bus0.ready, bus0.done,
                              bus0.bram_addra, bus0.bram_addrb, bus0.state_out);
    always @(negedge clk) mon(1, bus1.bram_en, bus1.ready, bus1.done,
                              bus1.bram_addra, bus1.bram_addrb, bus1.state_out);

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ramp;
        logic [127:0] rs;
        logic [1:0]   ts;
        int           c;
        int           gap;
        ramp = 128'h0F0E0D0C0B0A09080706050403020100;
        rst  = 1'b0;
        bus0.start = 1'b0; bus0.tsel = '0; bus0.state_in = '0;
        bus1.start = 1'b0; bus1.tsel = '0; bus1.state_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        check("rst_done", 0, bus0.done, 1'b0);
        check("rst_en", 0, bus0.bram_en, 1'b0);
        check("rst_addra", 0, bus0.bram_addra, 10'h0);
        check("rst_state_out", 0, bus0.state_out, 128'h0);
        check("rst_ready", 0, bus0.ready, 1'b1);

        // basic run, then table select 1
        launch(0, 2'd0, ramp); drop(0); go_to(last_done[0] + 1);
        launch(0, 2'd1, ramp); drop(0); go_to(last_done[0] + 1);

        // start while busy is ignored
        c = cyc;
        launch(0, 2'd2, ramp ^ 128'h5A5A_0000_FFFF_1234_0000_C3C3_8001_7E7E);
        drop(0);
        go_to(c + 4);
        bus0.start = 1'b1; bus0.tsel = 2'd3; bus0.state_in = {4{$urandom()}};
        drop(0);
        go_to(last_done[0] + 1);

        // back-to-back with start held high
        c = cyc;
        launch(0, 2'd1, ramp);
        go_to(last_done[0]);
        launch(0, 2'd1, {16{8'hA5}});
        drop(0);
        go_to(last_done[0] + 1);

        // reset in the middle of a run
        c = cyc;
        rs = {$urandom(), $urandom(), $urandom(), $urandom()};
        launch(0, 2'd3, rs); drop(0);
        go_to(c + 5);
        #1 rst = 1'b0;
        sq0.delete(); eq0.delete(); sq1.delete(); eq1.delete();
        #1;
        check("midrst_done", 0, bus0.done, 1'b0);
        check("midrst_en", 0, bus0.bram_en, 1'b0);
        check("midrst_addra", 0, bus0.bram_addra, 10'h0);
        check("midrst_addrb", 0, bus0.bram_addrb, 10'h0);
        check("midrst_state_out", 0, bus0.state_out, 128'h0);
        @(posedge clk); #1 rst = 1'b1;
        check("midrst_ready", 0, bus0.ready, 1'b1);
        go_to(cyc + 2);
        rs = {$urandom(), $urandom(), $urandom(), $urandom()};
        launch(0, 2'd2, rs); drop(0); go_to(last_done[0] + 1);

        // random traffic, gap 0 means start in the done cycle
        for (int i = 0; i < 12; i++) begin
            gap = $urandom_range(0, 3);
            ts  = 2'($urandom_range(0, 3));
            rs  = {$urandom(), $urandom(), $urandom(), $urandom()};
            go_to(last_done[0] + gap);
            launch(0, ts, rs); drop(0);
        end
        go_to(last_done[0] + 2);

        // RD_LAT = 1 build
        launch(1, 2'd0, ramp); drop(1); go_to(last_done[1] + 1);
        for (int i = 0; i < 6; i++) begin
            gap = $urandom_range(0, 3);
            ts  = 2'($urandom_range(0, 3));
            rs  = {$urandom(), $urandom(), $urandom(), $urandom()};
            go_to(last_done[1] + gap);
            launch(1, ts, rs); drop(1);
        end
        go_to(last_done[1] + 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sbox_layer_seq.md
# sbox_layer_seq

Sequencer that pushes one 128-bit masked AES state through a dual-port masked S-box BRAM (8-bit read, 10-bit address, registered output, 2-cycle read latency) and reassembles the 16 substituted bytes. It sits directly upstream and downstream of the BRAM: it drives both address ports and the enable, then collects DOA/DOB. It issues two bytes per cycle and absorbs the BRAM pipeline latency. It returns a registered 128-bit result with a one-cycle done pulse.

## Interface
Parameters:
- RD_LAT, 2, BRAM read latency in cycles from address sample to valid DO; legal values 1 or 2 (2 = output register enabled).
- NBYTES, 16, bytes per state; must be even.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted in IDLE or DONE.
- tsel  in  2  table select, sampled with start; forms address bits [9:8].
- state_in  in  128  masked state; byte i = state_in[8i+7:8i]; sampled with start.
- ready  out  1  high in IDLE and DONE.
- bram_en  out  1  drives BRAM ENA/ENB/REGCEA/REGCEB.
- bram_addra  out  10  port-A address.
- bram_addrb  out  10  port-B address.
- bram_doa  in  8  port-A data.
- bram_dob  in  8  port-B data.
- state_out  out  128  substituted state, same byte order as state_in.
- done  out  1  one-cycle pulse; state_out is valid from this cycle.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: accept start, then latch state_in and tsel, clear the issue counter k, and go to ISSUE.
- ISSUE: lasts NBYTES/2 cycles, k = 0..NBYTES/2-1.
  - bram_addra = {tsel, byte[2k]}; bram_addrb = {tsel, byte[2k+1]}.
  - After the last k, go to DRAIN.
- DRAIN: lasts RD_LAT cycles. Addresses hold their last value; bram_en stays high so the output register advances. Then go to DONE.
- Capture: the pair issued in ISSUE cycle k appears on DOA/DOB in cycle k+RD_LAT. It is written at the end of that cycle to state_out bytes 2k (DOA) and 2k+1 (DOB).
  - A valid/index delay line of depth RD_LAT tracks outstanding reads.
- DONE: done=1 for this cycle only.
  - start here is accepted as in IDLE (back-to-back); otherwise return to IDLE.
- start in ISSUE or DRAIN is ignored; latched inputs do not change.
- bram_en=1 exactly in ISSUE and DRAIN; 0 otherwise.
- Addresses are 0 whenever bram_en=0.
- state_out holds its value until it is overwritten byte-by-byte during the next run. It is only guaranteed valid from done until the next accepted start plus RD_LAT cycles.
- Reset (asserted anytime, including mid-run):
  - immediately: state=IDLE, done=0, bram_en=0, addresses=0, state_out=0, delay line cleared.
  - Outstanding BRAM reads are discarded. The BRAM's own synchronous reset is tied inactive outside this block.

## Timing
- Start sampled at edge E0; ISSUE occupies cycles 1..8.
- DRAIN occupies cycles 9..10 (RD_LAT=2); done is high in cycle 11.
- Latency: 11 cycles from start edge to done (NBYTES/2 + RD_LAT + 1).
- Throughput: one state per 11 cycles with start held high, because the next start is accepted in DONE.
- Last capture (bytes 14/15) occurs at the edge ending cycle 10; state_out is registered before done rises.
- ready is combinational from FSM state only.

## Structure
- Shared package: FSM state encoding, and the constant NBYTES/2 as the issue count.
- Keep the address-field layout constants (TSEL_MSB=9, TSEL_LSB=8) in the package; the BRAM wrappers use the same layout.
- One sub-module: sbox_rd_tracker, the RD_LAT-deep valid/pair-index shift register. Everything else lives in sbox_layer_seq.

## Test plan
Bench BRAM model: 2-cycle registered read returning (addr[7:0] ^ {6'b0, addr[9:8]}).
- Basic run: state_in bytes i=0x00..0x0F, tsel=0, one start pulse -> bram_addra 0x000,0x002..0x00E and bram_addrb 0x001..0x00F in cycles 1..8; done only in cycle 11; state_out = 0x0F0E..0100.
- Table select: tsel=2'b01 with the same state -> addra 0x100..0x10E; every state_out byte = i^0x01.
- Back-to-back: start held high with a new state_in (all 0xA5) presented in cycle 11 -> second done in cycle 22 with state_out all 0xA4 (tsel=1); bram_en stays high cycles 12..21 and low in cycle 11.
- Busy start: extra start pulse in cycle 4 -> no restart, done still only in cycle 11, result unchanged.
- Mid-run reset: rst low in cycle 5 ->
  - immediately: done=0, bram_en=0, addresses=0, state_out=0, ready=1 after release.
  - a fresh start then completes in 11 cycles with the correct result.
- RD_LAT=1 build -> done in cycle 10, same state_out as the basic run.
